// File: rtl/mod_inv_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mod_inv_arbiter_if                                       |
// | Description : Bundle between the modular-inverse arbiter, its          |
// |               requesters and the shared inverse engine.                |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
interface mod_inv_arbiter_if #(
   parameter int NREQ = 3
);
   // Requester side
   logic [NREQ-1:0]     req;
   logic [256*NREQ-1:0] req_operand;
   logic [NREQ-1:0]     req_ack;
   logic [NREQ-1:0]     resp_valid;
   logic [255:0]        resp_result;
   logic                resp_err;
   // Engine side
   logic                inv_start;
   logic [255:0]        inv_operand;
   logic                inv_done;
   logic [255:0]        inv_result;
   // Status
   logic                busy;

   // Arbiter view
   modport slave (
      input  req, req_operand, inv_done, inv_result,
      output req_ack, resp_valid, resp_result, resp_err,
             inv_start, inv_operand, busy
   );

   // Requester/engine view
   modport master (
      output req, req_operand, inv_done, inv_result,
      input  req_ack, resp_valid, resp_result, resp_err,
             inv_start, inv_operand, busy
   );
endinterface
`default_nettype wire

// File: rtl/mod_inv_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mod_inv_arbiter                                          |
// | Description : Round-robin arbiter sharing one modular-inverse engine   |
// |               among NREQ requesters, with zero-operand short-cut and   |
// |               engine hang timeout.                                     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module mod_inv_arbiter #(
   parameter int NREQ    = 3,
   parameter int TIMEOUT = 4096
) (
   input  logic               clk,
   input  logic               reset,
   mod_inv_arbiter_if.slave   bus
);

   localparam int          IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t           state_q;
   logic [IW-1:0]    ptr_q;
   logic [IW-1:0]    grant_q;
   logic [15:0]      cnt_q;

   logic [NREQ-1:0]  req_ack_q;
   logic [NREQ-1:0]  resp_valid_q;
   logic [255:0]     resp_result_q;
   logic             resp_err_q;
   logic             inv_start_q;
   logic [255:0]     inv_operand_q;
   logic             busy_q;

   logic             sel_found_d;
   logic [IW-1:0]    sel_idx_d;
   logic [255:0]     sel_op_d;
   logic [NREQ-1:0]  sel_oh_d;
   logic [NREQ-1:0]  grant_oh_d;
   logic [IW-1:0]    ptr_next_d;

   // Round-robin search: first requester with req high at or above ptr, wrapping
   always_comb begin
      int c;
      c           = 0;
      sel_found_d = 1'b0;
      sel_idx_d   = '0;
      // Walk downward so the candidate closest to ptr is the last (winning) write
      for (int k = NREQ - 1; k >= 0; k--) begin
         c = int'(ptr_q) + k;
         if (c >= NREQ) begin
            c = c - NREQ;
         end
         for (int i = 0; i < NREQ; i++) begin
            if ((c == i) && bus.req[i]) begin
               sel_found_d = 1'b1;
               sel_idx_d   = IW'(i);
            end
         end
      end
   end

   // Operand of the selected requester
   always_comb begin
      sel_op_d = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (sel_idx_d == IW'(i)) begin
            sel_op_d = bus.req_operand[i*256 +: 256];
         end
      end
   end

   assign sel_oh_d   = NREQ'(1) << sel_idx_d;
   assign grant_oh_d = NREQ'(1) << grant_q;
   assign ptr_next_d = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);

   // Transaction FSM; every output is a register updated here
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         ptr_q         <= '0;
         grant_q       <= '0;
         cnt_q         <= '0;
         req_ack_q     <= '0;
         resp_valid_q  <= '0;
         resp_result_q <= '0;
         resp_err_q    <= 1'b0;
         inv_start_q   <= 1'b0;
         inv_operand_q <= '0;
         busy_q        <= 1'b0;
      end else begin
         // Pulses default low; they are raised only on the edge that enters
         // the cycle in which they must be seen
         req_ack_q    <= '0;
         resp_valid_q <= '0;
         inv_start_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (sel_found_d) begin
                  grant_q       <= sel_idx_d;
                  req_ack_q     <= sel_oh_d;
                  inv_operand_q <= sel_op_d;
                  busy_q        <= 1'b1;
                  if (sel_op_d != '0) begin
                     inv_start_q <= 1'b1;
                     state_q     <= S_ISSUE;
                  end else begin
                     // Zero has no inverse: answer with an error, engine untouched
                     resp_valid_q  <= sel_oh_d;
                     resp_err_q    <= 1'b1;
                     resp_result_q <= '0;
                     state_q       <= S_RESP;
                  end
               end
            end
            S_ISSUE: begin
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               // Completion wins over a coincident timeout
               if (bus.inv_done) begin
                  resp_result_q <= bus.inv_result;
                  resp_err_q    <= 1'b0;
                  resp_valid_q  <= grant_oh_d;
                  state_q       <= S_RESP;
               end else if (cnt_q == TO_LAST) begin
                  resp_result_q <= '0;
                  resp_err_q    <= 1'b1;
                  resp_valid_q  <= grant_oh_d;
                  state_q       <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            S_RESP: begin
               ptr_q         <= ptr_next_d;
               resp_err_q    <= 1'b0;
               resp_result_q <= '0;
               busy_q        <= 1'b0;
               state_q       <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ack     = req_ack_q;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_result = resp_result_q;
   assign bus.resp_err    = resp_err_q;
   assign bus.inv_start   = inv_start_q;
   assign bus.inv_operand = inv_operand_q;
   assign bus.busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_inv_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_mod_inv_arbiter                                       |
// | Description : Self-checking bench for mod_inv_arbiter: vector table,   |
// |               engine model and response scoreboard.                    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_mod_inv_arbiter;

   localparam int NREQ    = 3;
   localparam int TIMEOUT = 16;
   localparam logic [255:0] INV2 =
      256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_7FFFFE18;

   typedef struct {
      logic [2:0]   req;
      logic [255:0] op;
      int           delay;
      logic [255:0] eng_res;
      logic [2:0]   exp_ack;
      logic         exp_err;
      logic [255:0] exp_res;
      int           lat;
   } vec_t;

   typedef struct {
      logic [2:0]   valid;
      logic         err;
      logic [255:0] res;
      int           lat;
   } sb_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;

   int n_tests = 0;
   int n_fail  = 0;

   logic [255:0] ops [NREQ];
   sb_t          sb [$];
   vec_t         vt [9];
   logic [2:0]   rr_exp [4];

   int           eng_delay  = 0;
   int           eng_cnt    = 0;
   bit           eng_fn     = 1'b0;
   logic [255:0] eng_result = '0;
   logic [255:0] eng_op     = '0;
   int           kick_req   = 0;
   int           kick_seen  = 0;

   int n_ack   = 0;
   int n_resp  = 0;
   int n_start = 0;
   int ack_cyc = 0;
   int last_g  = 0;

   mod_inv_arbiter_if #(.NREQ(NREQ)) bus ();

   mod_inv_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic int oh2idx(input logic [2:0] oh);
      int r;
      r = 0;
      for (int i = 0; i < NREQ; i++) if (oh[i]) r = i;
      return r;
   endfunction

   task automatic drive_ops();
      for (int i = 0; i < NREQ; i++) bus.req_operand[i*256 +: 256] = ops[i];
   endtask

   task automatic wait_ack(output logic [2:0] a);
      a = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (|bus.req_ack) begin
            a = bus.req_ack;
            break;
         end
      end
   endtask

   // Waits for both the DUT and the engine model to go quiet, then lingers
   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!bus.busy && eng_cnt == 0) begin
            done = 1'b1;
            break;
         end
      end
      repeat (3) @(negedge clk);
      chk("idle", 256'({done, bus.busy}), 256'(2'b10));
   endtask

   task automatic apply_reset(input int n);
      reset = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("reset_ctl", 256'({bus.req_ack, bus.resp_valid, bus.resp_err, bus.inv_start, bus.busy}), 256'(0));
         chk("reset_data", bus.resp_result | bus.inv_operand, 256'(0));
      end
      reset = 1'b1;
   endtask

   task automatic push_sb(input logic [2:0] v, input logic e, input logic [255:0] r, input int l);
      sb_t s;
      s = '{v, e, r, l};
      sb.push_back(s);
   endtask

   task automatic run_vec(input vec_t v);
      int g;
      int s0;
      logic [2:0] a;
      g = oh2idx(v.exp_ack);
      for (int i = 0; i < NREQ; i++) ops[i] = (i == g) ? v.op : (256'hBAD0 + 256'(i));
      drive_ops();
      eng_delay  = v.delay;
      eng_fn     = 1'b0;
      eng_result = v.eng_res;
      push_sb(v.exp_ack, v.exp_err, v.exp_res, v.lat);
      s0 = n_start;
      bus.req = v.req;
      wait_ack(a);
      chk("grant", 256'(a), 256'(v.exp_ack));
      bus.req = '0;
      wait_idle();
      chk("inv_start_count", 256'(n_start - s0), 256'((v.op != '0) ? 1 : 0));
      chk("sb_drained", 256'(sb.size()), 256'(0));
   endtask

   // Inverse engine model: answers delay cycles after inv_start (never if delay<=0)
   initial begin
      bus.inv_done   = 1'b0;
      bus.inv_result = '0;
      forever begin
         @(negedge clk);
         bus.inv_done = 1'b0;
         if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
               bus.inv_done   = 1'b1;
               bus.inv_result = eng_fn ? ~eng_op : eng_result;
            end
         end
         if (reset && bus.inv_start) begin
            eng_op  = bus.inv_operand;
            eng_cnt = (eng_delay > 0) ? eng_delay : 0;
         end
         if (kick_req != kick_seen) begin
            kick_seen      = kick_req;
            bus.inv_done   = 1'b1;
            bus.inv_result = '1;
         end
      end
   end

   // Monitor: grant ordering, engine operand, scoreboard compare on responses
   initial begin
      sb_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            n_resp = n_ack;
         end else begin
            if (|bus.req_ack) begin
               chk("ack_after_resp", 256'(n_ack), 256'(n_resp));
               chk("ack_onehot", 256'($countones(bus.req_ack)), 256'(1));
               last_g  = oh2idx(bus.req_ack);
               ack_cyc = cyc;
               n_ack++;
            end
            if (bus.inv_start) begin
               n_start++;
               chk("inv_operand", bus.inv_operand, ops[last_g]);
            end
            if (|bus.resp_valid) begin
               n_resp++;
               if (sb.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_resp: got resp_valid %b, required none", bus.resp_valid);
               end else begin
                  e = sb.pop_front();
                  chk("resp_valid", 256'(bus.resp_valid), 256'(e.valid));
                  chk("resp_err", 256'(bus.resp_err), 256'(e.err));
                  chk("resp_result", bus.resp_result, e.res);
                  chk("resp_latency", 256'(cyc - ack_cyc), 256'(e.lat));
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish by 500000, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2:0] a;
      //          req     op            dly eng_res       ack     err   exp_res       lat
      vt[0] = '{3'b001, 256'd2,        10, INV2,         3'b001, 1'b0, INV2,         11};
      vt[1] = '{3'b010, 256'd0,         5, 256'd0,       3'b010, 1'b1, 256'd0,        0};
      vt[2] = '{3'b011, 256'd5,         3, 256'h1234,    3'b001, 1'b0, 256'h1234,     4};
      vt[3] = '{3'b101, 256'hABCDEF,    1, 256'h55,      3'b100, 1'b0, 256'h55,       2};
      vt[4] = '{3'b100, 256'd9,        -1, 256'h77,      3'b100, 1'b1, 256'd0,       17};
      vt[5] = '{3'b001, 256'd11,       16, 256'hC0FFEE,  3'b001, 1'b0, 256'hC0FFEE, 17};
      vt[6] = '{3'b010, 256'd13,       20, 256'hDEAD,    3'b010, 1'b1, 256'd0,       17};
      vt[7] = '{3'b110, 256'd17,       15, 256'hBEEF,    3'b100, 1'b0, 256'hBEEF,    16};
      vt[8] = '{3'b110, {1'b1, 255'd3}, 2, 256'h1,       3'b010, 1'b0, 256'h1,        3};
      rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};

      reset   = 1'b0;
      bus.req = '0;
      for (int i = 0; i < NREQ; i++) ops[i] = '0;
      drive_ops();
      apply_reset(3);
      @(negedge clk);
      chk("post_reset_busy", 256'(bus.busy), 256'(0));

      for (int i = 0; i < 9; i++) run_vec(vt[i]);

      // Contention: all three held high, round-robin 0,1,2,0
      apply_reset(2);
      for (int i = 0; i < NREQ; i++) ops[i] = 256'h1000 + 256'(i);
      drive_ops();
      eng_delay = 2;
      eng_fn    = 1'b1;
      for (int k = 0; k < 4; k++) push_sb(rr_exp[k], 1'b0, ~ops[oh2idx(rr_exp[k])], 3);
      bus.req = 3'b111;
      for (int k = 0; k < 4; k++) begin
         wait_ack(a);
         chk("rr_grant", 256'(a), 256'(rr_exp[k]));
      end
      bus.req = '0;
      wait_idle();
      chk("rr_sb_drained", 256'(sb.size()), 256'(0));

      // Reset in the middle of WAIT: no response, late inv_done ignored
      eng_fn = 1'b0;
      ops[0] = 256'd7;
      drive_ops();
      eng_delay  = 8;
      eng_result = 256'h99;
      bus.req    = 3'b001;
      wait_ack(a);
      chk("midwait_grant", 256'(a), 256'(3'b001));
      bus.req = '0;
      repeat (3) @(negedge clk);
      apply_reset(2);
      wait_idle();
      chk("midwait_no_resp", 256'(n_resp), 256'(n_ack));
      run_vec('{3'b100, 256'd21, 4, 256'h4242, 3'b100, 1'b0, 256'h4242, 5});

      // Pointer cleared by reset: after serving 0 the pointer is 1, reset returns it to 0
      run_vec('{3'b001, 256'd23, 2, 256'h2323, 3'b001, 1'b0, 256'h2323, 3});
      apply_reset(2);
      run_vec('{3'b011, 256'd25, 2, 256'h2525, 3'b001, 1'b0, 256'h2525, 3});

      // inv_done pulsed while idle must not start a response
      kick_req++;
      wait_idle();
      chk("spurious_done_sb", 256'(sb.size()), 256'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mod_inv_arbiter.md
MOD_INV_ARBITER -- requirements
Module: mod_inv_arbiter

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- NREQ, 3, number of requesters (point-add, point-double, affine-convert).
- TIMEOUT, 4096, maximum WAIT cycles before the engine is declared hung.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- req, input, NREQ, per-requester inversion request level.
- req_operand, input, 256*NREQ, operand for requester i in bits [256*i+255 : 256*i].
- req_ack, output, NREQ, one-hot grant pulse.
- resp_valid, output, NREQ, one-hot response pulse.
- resp_result, output, 256, inverse mod p, valid with resp_valid.
- resp_err, output, 1, error flag (zero operand or timeout), valid with resp_valid.
- inv_start, output, 1, start pulse to the shared inverse engine.
- inv_operand, output, 256, operand to the engine; held stable from ISSUE through WAIT.
- inv_done, input, 1, engine completion.
- inv_result, input, 256, engine result, sampled when inv_done=1.
- busy, output, 1, high in every state except IDLE.

Function
REQ-003 The block SHALL implement four states: IDLE, ISSUE, WAIT and RESP; all outputs SHALL be registered.
REQ-004 In IDLE with any req bit high at an edge, the block SHALL select the first requester with req high, searching upward from priority pointer ptr with wrap-around modulo NREQ.
REQ-005 At that same edge, the block SHALL latch the grant index and req_operand of the selected requester, and SHALL assert req_ack[grant] for exactly the following cycle.
REQ-006 If the latched operand is nonzero, the block SHALL go IDLE->ISSUE; if it is zero, the block SHALL go IDLE->RESP with resp_err=1 and resp_result=0, and SHALL NOT pulse inv_start.
REQ-007 In ISSUE, inv_start SHALL be 1 for exactly one cycle and inv_operand SHALL equal the latched operand; the next state SHALL be WAIT.
REQ-008 In WAIT, a 16-bit cycle counter SHALL start at 0 on entry and increment every cycle.
REQ-009 In WAIT, inv_done=1 at an edge SHALL latch inv_result into resp_result with resp_err=0 and go to RESP.
REQ-010 In WAIT, when the counter reaches TIMEOUT-1 without inv_done, the block SHALL go to RESP with resp_err=1 and resp_result=0.
REQ-011 If inv_done and the timeout occur at the same edge, inv_done SHALL take precedence.
REQ-012 In RESP, resp_valid[grant] SHALL be 1 for exactly one cycle, and the block SHALL then go to IDLE.
REQ-013 On leaving RESP, ptr SHALL be set to (grant+1) mod NREQ.
REQ-014 inv_done asserted outside WAIT SHALL be ignored.
REQ-015 req bits are sampled only in IDLE; a req dropped before its ack SHALL receive no ack and no response.
REQ-016 A requester SHALL hold req_operand stable while req is high until its req_ack.
REQ-017 Latency, nonzero operand, from the grant edge: inv_start is high in cycle +1; resp_valid is high in the cycle after the inv_done edge.
REQ-018 Latency, zero operand: resp_valid SHALL be high in cycle +1 after the grant edge.
REQ-019 At most one grant SHALL be outstanding at a time; simultaneous requests SHALL be served one per transaction in round-robin order.
REQ-020 Outside ISSUE, resp_valid and req_ack SHALL be 0 except as specified above, and inv_start SHALL be 0.

Reset
REQ-021 While reset=0, the block SHALL set state=IDLE, ptr=0, counter=0, and drive req_ack, resp_valid, resp_result, resp_err, inv_start, inv_operand and busy to 0.
REQ-022 Assertion of reset in any state SHALL abandon the in-flight transaction with no response; a later inv_done SHALL be ignored.
REQ-023 After reset deassertion, the first grant SHALL go to the lowest-index requester with req high.

Verification
REQ-024 The bench SHALL cover single request: req=3'b001, operand=2, engine returns 0x7FFFFFFF...FFFF7FFFFE18 after 10 cycles -> req_ack=3'b001 pulse, one inv_start, resp_valid=3'b001 with that result, resp_err=0.
REQ-025 The bench SHALL cover contention: req=3'b111 held after reset -> grant order 0,1,2,0; each resp_valid precedes the next req_ack.
REQ-026 The bench SHALL cover zero operand: req=3'b010, operand=0 -> req_ack=3'b010, resp_valid=3'b010 one cycle later, resp_err=1, inv_start never asserted.
REQ-027 The bench SHALL cover timeout: TIMEOUT=16, engine never responds -> resp_err=1, resp_result=0 exactly 16 cycles after WAIT entry; a late inv_done is ignored.
REQ-028 The bench SHALL cover the done/timeout tie: inv_done on the timeout edge -> resp_err=0 and resp_result=inv_result.
REQ-029 The bench SHALL cover reset mid-WAIT: reset=0 for 2 cycles -> all outputs 0, no resp_valid, then req=3'b100 served normally as the first grant.
